// File: rtl/srt4_otf_converter.sv
// SRT-4 quotient on-the-fly converter.
// Takes one signed radix-4 digit per iteration and keeps Q and QM = Q-1
// up to date, so the corrected quotient is a simple select at the end:
// QM when the final remainder is negative, Q otherwise.
//
// Handshake: a digit transfers on a rising edge where digit_valid and
// digit_ready are both high; digit_ready depends only on the FSM state,
// never on digit_valid, and the producer holds q_mag/q_neg stable while
// digit_valid is high and the digit has not yet transferred.
module srt4_otf_converter #(
    parameter int Q_WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               digit_valid,
    output logic               digit_ready,
    input  logic [1:0]         q_mag,
    input  logic               q_neg,
    input  logic               rem_valid,
    input  logic               rem_neg,
    output logic               busy,
    output logic [Q_WIDTH-1:0] quotient,
    output logic               q_valid,
    output logic               digit_err
);

    localparam int ITER  = Q_WIDTH / 2;
    localparam int CNT_W = $clog2(ITER + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITER - 1);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] COLLECT  = 2'd1;
    localparam logic [1:0] WAIT_REM = 2'd2;
    localparam logic [1:0] DONE     = 2'd3;

    // State register is left visible by name so checkers can bind to it.
    logic [1:0]         state;
    logic [Q_WIDTH-1:0] q_r;
    logic [Q_WIDTH-1:0] qm_r;
    logic [CNT_W-1:0]   count_r;

    logic               illegal;
    logic [1:0]         mag_eff;
    logic               q_from_qm;
    logic               qm_from_q;
    logic [1:0]         q_tail;
    logic [1:0]         qm_tail;
    logic [Q_WIDTH-1:0] q_src;
    logic [Q_WIDTH-1:0] qm_src;
    logic [Q_WIDTH-1:0] q_next;
    logic [Q_WIDTH-1:0] qm_next;
    logic               accept;

    assign digit_ready = (state == COLLECT);
    assign busy        = (state == COLLECT) || (state == WAIT_REM);
    assign q_valid     = (state == DONE);
    assign accept      = digit_valid && digit_ready;

    // Decode the digit and pick the source register and appended bits for Q and QM.
    // Negative digits borrow from QM; the appended pair is d mod 4 (Q) and (d-1) mod 4 (QM).
    always_comb begin
        illegal   = (q_mag == 2'b11);
        mag_eff   = illegal ? 2'b00 : q_mag;
        q_from_qm = 1'b0;
        qm_from_q = 1'b0;
        q_tail    = 2'b00;
        qm_tail   = 2'b11;
        if (mag_eff != 2'b00) begin
            if (!q_neg) begin
                q_tail    = mag_eff;
                qm_from_q = 1'b1;
                qm_tail   = mag_eff - 2'd1;
            end else begin
                q_from_qm = 1'b1;
                q_tail    = ~mag_eff + 2'd1;
                qm_tail   = ~mag_eff;
            end
        end
        q_src   = q_from_qm ? qm_r : q_r;
        qm_src  = qm_from_q ? q_r : qm_r;
        q_next  = {q_src[Q_WIDTH-3:0], q_tail};
        qm_next = {qm_src[Q_WIDTH-3:0], qm_tail};
    end

    // FSM, Q/QM pair, digit counter, sticky error flag and the held quotient.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            q_r       <= '0;
            qm_r      <= '1;
            count_r   <= '0;
            quotient  <= '0;
            digit_err <= 1'b0;
        end else if (start) begin
            // Start from any state re-initialises; a same-cycle digit is dropped.
            state     <= COLLECT;
            q_r       <= '0;
            qm_r      <= '1;
            count_r   <= '0;
            digit_err <= 1'b0;
        end else begin
            case (state)
                COLLECT: begin
                    if (accept) begin
                        q_r     <= q_next;
                        qm_r    <= qm_next;
                        count_r <= count_r + CNT_W'(1);
                        if (illegal) begin
                            digit_err <= 1'b1;
                        end
                        if (count_r == LAST_CNT) begin
                            state <= WAIT_REM;
                        end
                    end
                end
                WAIT_REM: begin
                    if (rem_valid) begin
                        quotient <= rem_neg ? qm_r : q_r;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_srt4_otf_converter.sv
// Directed bench for srt4_otf_converter at Q_WIDTH=8 (four digits per division).
module tb_srt4_otf_converter;

    localparam int W = 8;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_COLLECT  = 2'd1;
    localparam logic [1:0] S_WAIT_REM = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic         digit_valid;
    logic         digit_ready;
    logic [1:0]   q_mag;
    logic         q_neg;
    logic         rem_valid;
    logic         rem_neg;
    logic         busy;
    logic [W-1:0] quotient;
    logic         q_valid;
    logic         digit_err;

    int errors = 0;
    int checks = 0;

    srt4_otf_converter #(.Q_WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .digit_valid (digit_valid),
        .digit_ready (digit_ready),
        .q_mag       (q_mag),
        .q_neg       (q_neg),
        .rem_valid   (rem_valid),
        .rem_neg     (rem_neg),
        .busy        (busy),
        .quotient    (quotient),
        .q_valid     (q_valid),
        .digit_err   (digit_err)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_raw(input logic [1:0] mag, input logic neg, input int stalls);
        for (int i = 0; i < stalls; i++) begin
            digit_valid = 1'b0;
            check("stall_ready", 32'(digit_ready), 32'd1);
            tick();
        end
        digit_valid = 1'b1;
        q_mag       = mag;
        q_neg       = neg;
        tick();
        digit_valid = 1'b0;
        q_mag       = 2'b00;
        q_neg       = 1'b0;
    endtask

    task automatic send_d(input int d, input int stalls);
        logic [1:0] m;
        m = (d < 0) ? 2'(-d) : 2'(d);
        send_raw(m, d < 0, stalls);
    endtask

    // Present the remainder sign, then check the DONE cycle and the return to IDLE.
    task automatic finish_rem(input logic neg, input logic [W-1:0] exp_q, input string tag);
        rem_valid = 1'b1;
        rem_neg   = neg;
        tick();
        rem_valid = 1'b0;
        rem_neg   = 1'b0;
        check({tag, "_quotient"}, 32'(quotient), 32'(exp_q));
        check({tag, "_q_valid"}, 32'(q_valid), 32'd1);
        check({tag, "_busy_done"}, 32'(busy), 32'd0);
        tick();
        check({tag, "_q_valid_off"}, 32'(q_valid), 32'd0);
        check({tag, "_state_idle"}, 32'(dut.state), 32'(S_IDLE));
    endtask

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        digit_valid = 1'b0;
        q_mag       = 2'b00;
        q_neg       = 1'b0;
        rem_valid   = 1'b0;
        rem_neg     = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_quotient", 32'(quotient), 32'd0);
        check("rst_q_valid", 32'(q_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(digit_ready), 32'd0);
        check("rst_err", 32'(digit_err), 32'd0);
        check("rst_state", 32'(dut.state), 32'(S_IDLE));
        rst_n = 1'b1;
        tick();

        // 1: +2,+1,0,-1 -> 128+16+0-1 = 0x8F; QM = 0x8E
        do_start();
        check("t1_ready", 32'(digit_ready), 32'd1);
        check("t1_busy", 32'(busy), 32'd1);
        send_d(2, 0);
        send_d(1, 0);
        send_d(0, 0);
        send_d(-1, 0);
        check("t1_ready_wait", 32'(digit_ready), 32'd0);
        check("t1_busy_wait", 32'(busy), 32'd1);
        finish_rem(1'b0, 8'h8F, "t1a");
        do_start();
        send_d(2, 0);
        send_d(1, 0);
        send_d(0, 0);
        send_d(-1, 0);
        finish_rem(1'b1, 8'h8E, "t1b");

        // 2: -2,-2,-2,-2 -> -170 mod 256 = 0x56; QM = 0x55
        do_start();
        for (int i = 0; i < 4; i++) send_d(-2, 0);
        check("t2_state_wait", 32'(dut.state), 32'(S_WAIT_REM));
        check("t2_qm", 32'(dut.qm_r), 32'h55);
        finish_rem(1'b0, 8'h56, "t2");

        // 3: +1,-2,+2,-1 with 3 stall cycles between -> 64-32+8-1 = 0x27
        do_start();
        send_d(1, 0);
        send_d(-2, 3);
        send_d(2, 3);
        send_d(-1, 3);
        check("t3_ready_after", 32'(digit_ready), 32'd0);
        finish_rem(1'b0, 8'h27, "t3");

        // 4: +1, illegal, +1, +1 -> 64+0+4+1 = 0x45, digit_err sticky
        do_start();
        send_d(1, 0);
        send_raw(2'b11, 1'b0, 0);
        check("t4_err_set", 32'(digit_err), 32'd1);
        send_d(1, 0);
        send_d(1, 0);
        check("t4_err_sticky", 32'(digit_err), 32'd1);
        finish_rem(1'b0, 8'h45, "t4");
        check("t4_err_held_idle", 32'(digit_err), 32'd1);
        do_start();
        check("t4_err_clear", 32'(digit_err), 32'd0);

        // 5: abort after 2 digits; a digit offered with start is dropped
        send_d(-2, 0);
        send_d(1, 0);
        digit_valid = 1'b1;
        q_mag       = 2'b10;
        q_neg       = 1'b0;
        do_start();
        digit_valid = 1'b0;
        check("t5_quotient_kept", 32'(quotient), 32'h45);
        check("t5_restart_state", 32'(dut.state), 32'(S_COLLECT));
        send_d(2, 0);
        send_d(1, 0);
        send_d(0, 0);
        send_d(-1, 0);
        // Start in the DONE cycle: pulse still seen, then straight to COLLECT
        rem_valid = 1'b1;
        tick();
        rem_valid = 1'b0;
        check("t5_quotient", 32'(quotient), 32'h8F);
        check("t5_q_valid", 32'(q_valid), 32'd1);
        do_start();
        check("t5_done_start_state", 32'(dut.state), 32'(S_COLLECT));
        check("t5_done_start_qv", 32'(q_valid), 32'd0);

        // 6: reset mid-run after 2 digits, then stray pulses in IDLE
        send_d(1, 0);
        send_d(1, 0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("t6_quotient", 32'(quotient), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_ready", 32'(digit_ready), 32'd0);
        check("t6_q_valid", 32'(q_valid), 32'd0);
        check("t6_err", 32'(digit_err), 32'd0);
        check("t6_state", 32'(dut.state), 32'(S_IDLE));
        rem_valid = 1'b1;
        tick();
        rem_valid = 1'b0;
        check("t6_idle_rem_qv", 32'(q_valid), 32'd0);
        digit_valid = 1'b1;
        q_mag       = 2'b01;
        tick();
        digit_valid = 1'b0;
        check("t6_idle_dig_qv", 32'(q_valid), 32'd0);
        tick();
        check("t6_idle_qv2", 32'(q_valid), 32'd0);
        check("t6_idle_state", 32'(dut.state), 32'(S_IDLE));
        check("t6_idle_q", 32'(dut.q_r), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
